dram_write_merger: RTL and testbench

DRAM_WRITE_MERGER -- requirements
Module: DramWriteMerger

---
 rtl/dram_write_merger.sv | 134 +++++++++++++
 tb/tb_dram_write_merger.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_write_merger.sv
// Write-combining stage between collector writes and DRAM: a single hold line merges
// same-address beats, and a registered output slot presents one DRAM beat at a time.
module dram_write_merger #(
    parameter int GBW     = 32,
    parameter int DBW     = 16,
    parameter int CSIZE   = 32,
    parameter int TIMEOUT = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      cw_rdy,
    output logic                      cw_ack,
    input  logic [GBW-1:0]            i_cwa,
    input  logic [CSIZE-1:0][DBW-1:0] i_cwd,
    input  logic [CSIZE-1:0]          i_cw_mask,
    input  logic                      i_flush,
    output logic                      dramw_rdy,
    input  logic                      dramw_ack,
    output logic [GBW-1:0]            o_dramwa,
    output logic [CSIZE-1:0][DBW-1:0] o_dramwd,
    output logic [CSIZE-1:0]          o_dramw_mask,
    output logic                      o_idle
);

    typedef enum logic {EMPTY, HOLD} state_e;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_e                    state_q, state_d;
    logic [7:0]                ic_q, ic_d;
    logic [GBW-1:0]            hb_addr_q, hb_addr_d;
    logic [CSIZE-1:0][DBW-1:0] hb_data_q, hb_data_d;
    logic [CSIZE-1:0]          hb_mask_q, hb_mask_d;
    logic                      os_rdy_q, os_rdy_d;
    logic [GBW-1:0]            os_addr_q, os_addr_d;
    logic [CSIZE-1:0][DBW-1:0] os_data_q, os_data_d;
    logic [CSIZE-1:0]          os_mask_q, os_mask_d;

    logic                      os_free, addr_hit, beat_nz, move;
    logic [CSIZE-1:0][DBW-1:0] merge_data;

    // The output slot can take a new line if empty or being drained this cycle.
    assign os_free  = !os_rdy_q || dramw_ack;
    assign addr_hit = (state_q == HOLD) && (i_cwa == hb_addr_q);
    assign beat_nz  = |i_cw_mask;
    assign cw_ack   = i_rst && cw_rdy && !i_flush && ((state_q == EMPTY) || addr_hit || os_free);

    for (genvar k = 0; k < CSIZE; k++) begin : g_lane
        assign merge_data[k] = i_cw_mask[k] ? i_cwd[k] : hb_data_q[k];
    end

    always_comb begin
        state_d   = state_q;
        ic_d      = ic_q;
        hb_addr_d = hb_addr_q;
        hb_data_d = hb_data_q;
        hb_mask_d = hb_mask_q;
        move      = 1'b0;
        if (state_q == EMPTY) begin
            if (cw_ack && beat_nz) begin
                hb_addr_d = i_cwa;
                hb_data_d = i_cwd;
                hb_mask_d = i_cw_mask;
                state_d   = HOLD;
                ic_d      = 8'd0;
            end
        end else begin
            if (cw_ack) begin
                ic_d = 8'd0;
                if (beat_nz && addr_hit) begin
                    hb_data_d = merge_data;
                    hb_mask_d = hb_mask_q | i_cw_mask;
                end else if (beat_nz) begin
                    move      = 1'b1;
                    hb_addr_d = i_cwa;
                    hb_data_d = i_cwd;
                    hb_mask_d = i_cw_mask;
                end
            end else if (((ic_q == TO) || i_flush) && os_free) begin
                move    = 1'b1;
                state_d = EMPTY;
                ic_d    = 8'd0;
            end else if (ic_q != TO) begin
                ic_d = ic_q + 8'd1;
            end
        end
    end

    always_comb begin
        os_rdy_d  = os_rdy_q;
        os_addr_d = os_addr_q;
        os_data_d = os_data_q;
        os_mask_d = os_mask_q;
        if (move) begin
            os_rdy_d  = 1'b1;
            os_addr_d = hb_addr_q;
            os_data_d = hb_data_q;
            os_mask_d = hb_mask_q;
        end else if (dramw_ack) begin
            os_rdy_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= EMPTY;
            ic_q      <= 8'd0;
            hb_addr_q <= '0;
            hb_data_q <= '0;
            hb_mask_q <= '0;
            os_rdy_q  <= 1'b0;
            os_addr_q <= '0;
            os_data_q <= '0;
            os_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            ic_q      <= ic_d;
            hb_addr_q <= hb_addr_d;
            hb_data_q <= hb_data_d;
            hb_mask_q <= hb_mask_d;
            os_rdy_q  <= os_rdy_d;
            os_addr_q <= os_addr_d;
            os_data_q <= os_data_d;
            os_mask_q <= os_mask_d;
        end
    end

    assign dramw_rdy    = os_rdy_q;
    assign o_dramwa     = os_addr_q;
    assign o_dramwd     = os_data_q;
    assign o_dramw_mask = os_mask_q;
    assign o_idle       = (state_q == EMPTY) && !os_rdy_q;

endmodule

// File: tb/tb_dram_write_merger.sv
// Bench for dram_write_merger: directed scenarios plus a randomized run checked
// against a line-level reference model and a lane-level memory scoreboard.
module tb_dram_write_merger;

    localparam int GBW = 32, DBW = 16, CSIZE = 32, TIMEOUT = 8;
    typedef logic [CSIZE-1:0][DBW-1:0] data_t;
    typedef struct packed { logic [GBW-1:0] a; data_t d; logic [CSIZE-1:0] m; } line_t;

    logic i_clk = 0, i_rst = 0, cw_rdy = 0, i_flush = 0, dramw_ack = 0;
    logic cw_ack, dramw_rdy, o_idle;
    logic [GBW-1:0] i_cwa = '0, o_dramwa;
    data_t i_cwd = '0, o_dramwd;
    logic [CSIZE-1:0] i_cw_mask = '0, o_dramw_mask;

    dram_write_merger #(.GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .cw_rdy(cw_rdy), .cw_ack(cw_ack), .i_cwa(i_cwa),
        .i_cwd(i_cwd), .i_cw_mask(i_cw_mask), .i_flush(i_flush), .dramw_rdy(dramw_rdy),
        .dramw_ack(dramw_ack), .o_dramwa(o_dramwa), .o_dramwd(o_dramwd),
        .o_dramw_mask(o_dramw_mask), .o_idle(o_idle));

    always #5 i_clk = ~i_clk;

    int n_checks = 0, n_err = 0;

    // Reference model: the line being collected, the beats waiting for DRAM, and memories.
    bit    m_held;
    line_t m_line, m_last;
    int    m_idle;
    line_t m_out_q[$];
    bit    exp_ack, exp_rdy, exp_idle;
    data_t ref_mem[logic [GBW-1:0]];
    data_t dram_mem[logic [GBW-1:0]];
    logic [GBW-1:0] seen_q[$];

    function automatic data_t rand_data();
        data_t d;
        for (int k = 0; k < CSIZE; k++) d[k] = DBW'($urandom);
        return d;
    endfunction

    function automatic void model_reset();
        m_held = 0; m_idle = 0; m_line = '0; m_last = '0; m_out_q.delete();
    endfunction

    function automatic void model_eval();
        bit free_slot = (m_out_q.size() == 0) || dramw_ack;
        exp_ack  = i_rst && cw_rdy && !i_flush && (!m_held || i_cwa == m_line.a || free_slot);
        exp_rdy  = m_out_q.size() != 0;
        exp_idle = !m_held && !exp_rdy;
    endfunction

    function automatic void model_clock();
        bit free_slot, acc;
        line_t beat;
        data_t tmp;
        if (!i_rst) begin model_reset(); return; end
        free_slot = (m_out_q.size() == 0) || dramw_ack;
        acc = i_rst && cw_rdy && !i_flush && (!m_held || i_cwa == m_line.a || free_slot);
        beat.a = i_cwa; beat.d = i_cwd; beat.m = i_cw_mask;
        if (acc && beat.m != 0) begin
            tmp = ref_mem.exists(beat.a) ? ref_mem[beat.a] : '0;
            for (int k = 0; k < CSIZE; k++) if (beat.m[k]) tmp[k] = beat.d[k];
            ref_mem[beat.a] = tmp;
        end
        if (m_out_q.size() != 0 && dramw_ack) void'(m_out_q.pop_front());
        if (acc && beat.m != 0) begin
            if (m_held && beat.a == m_line.a) begin
                for (int k = 0; k < CSIZE; k++) if (beat.m[k]) m_line.d[k] = beat.d[k];
                m_line.m |= beat.m;
            end else begin
                if (m_held) begin m_out_q.push_back(m_line); m_last = m_line; end
                m_line = beat; m_held = 1;
            end
            m_idle = 0;
        end else if (acc) begin
            m_idle = 0;
        end else if (m_held) begin
            if ((m_idle >= TIMEOUT || i_flush) && free_slot) begin
                m_out_q.push_back(m_line); m_last = m_line; m_held = 0; m_idle = 0;
            end else if (m_idle < TIMEOUT) m_idle++;
        end
    endfunction

    task automatic drive(input logic rdy, input logic [GBW-1:0] a, input logic [CSIZE-1:0] m,
                         input data_t d, input logic fl, input logic ack);
        cw_rdy = rdy; i_cwa = a; i_cw_mask = m; i_cwd = d; i_flush = fl; dramw_ack = ack;
    endtask

    task automatic observe();
        @(negedge i_clk);
        model_eval();
    endtask

    task automatic tick();
        data_t tmp;
        if (dramw_rdy === 1'b1 && dramw_ack) begin
            seen_q.push_back(o_dramwa);
            tmp = dram_mem.exists(o_dramwa) ? dram_mem[o_dramwa] : '0;
            for (int k = 0; k < CSIZE; k++) if (o_dramw_mask[k]) tmp[k] = o_dramwd[k];
            dram_mem[o_dramwa] = tmp;
        end
        model_clock();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_rdy(input int max, output int n, output bit got);
        got = 0; n = max;
        for (int i = 0; i < max; i++) begin
            observe();
            if (dramw_rdy === 1'b1) begin got = 1; n = i; return; end
            tick();
        end
    endtask

    task automatic test_reset();
        drive(1, 32'h100, '1, rand_data(), 0, 0);
        #3;
        n_checks++; if (dramw_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %0b exp 0", dramw_rdy); end
        n_checks++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %0b exp 1", o_idle); end
        n_checks++; if (cw_ack !== 1'b0) begin n_err++; $display("FAIL reset_cw_ack got %0b exp 0", cw_ack); end
        n_checks++; if (o_dramwa !== '0 || o_dramw_mask !== '0 || o_dramwd !== '0) begin
            n_err++; $display("FAIL reset_out got a=%0h m=%0h exp 0", o_dramwa, o_dramw_mask); end
        @(negedge i_clk);
        i_rst = 1; model_reset();
        drive(0, '0, '0, '0, 0, 0);
        @(posedge i_clk); #1;
    endtask

    task automatic test_merge();
        data_t d1 = rand_data(), d2 = rand_data(), e;
        int n; bit got;
        e = d1;
        for (int k = 4; k < 8; k++) e[k] = d2[k];
        drive(1, 32'h100, 32'h0000000F, d1, 0, 0); observe();
        n_checks++; if (cw_ack !== 1'b1) begin n_err++; $display("FAIL merge_ack1 got %0b exp 1", cw_ack); end
        tick();
        drive(1, 32'h100, 32'h000000F0, d2, 0, 0); observe();
        n_checks++; if (cw_ack !== 1'b1) begin n_err++; $display("FAIL merge_ack2 got %0b exp 1", cw_ack); end
        tick();
        drive(0, '0, '0, '0, 0, 0);
        wait_rdy(30, n, got);
        n_checks++; if (!got || n != TIMEOUT + 1) begin n_err++; $display("FAIL merge_latency got %0d exp %0d", n, TIMEOUT + 1); end
        n_checks++; if (o_dramwa !== 32'h100 || o_dramw_mask !== 32'h000000FF) begin
            n_err++; $display("FAIL merge_beat got a=%0h m=%0h exp a=100 m=ff", o_dramwa, o_dramw_mask); end
        n_checks++; if (o_dramwd[7:0] !== e[7:0]) begin n_err++; $display("FAIL merge_data got %0h exp %0h", o_dramwd[7:0], e[7:0]); end
        tick();
        drive(0, '0, '0, '0, 0, 1); observe(); tick();
        drive(0, '0, '0, '0, 0, 0); observe();
        n_checks++; if (o_idle !== 1'b1 || dramw_rdy !== 1'b0) begin
            n_err++; $display("FAIL merge_idle got idle=%0b rdy=%0b exp 1/0", o_idle, dramw_rdy); end
        tick();
    endtask

    task automatic test_overwrite();
        data_t d1 = rand_data(), d2 = rand_data();
        int n; bit got, extra = 0;
        d1[0] = 16'd5; d2[0] = 16'd9;
        drive(1, 32'h200, 32'h1, d1, 0, 0); observe(); tick();
        drive(1, 32'h200, 32'h1, d2, 0, 0); observe(); tick();
        drive(0, '0, '0, '0, 0, 0);
        wait_rdy(30, n, got);
        n_checks++; if (!got || o_dramwd[0] !== 16'd9 || o_dramw_mask !== 32'h1 || o_dramwa !== 32'h200) begin
            n_err++; $display("FAIL overwrite_beat got lane0=%0d m=%0h a=%0h exp 9/1/200", o_dramwd[0], o_dramw_mask, o_dramwa); end
        tick();
        drive(0, '0, '0, '0, 0, 1); observe(); tick();
        drive(0, '0, '0, '0, 0, 0);
        for (int i = 0; i < TIMEOUT + 3; i++) begin observe(); if (dramw_rdy !== 1'b0) extra = 1; tick(); end
        n_checks++; if (extra) begin n_err++; $display("FAIL overwrite_single got second beat exp none"); end
    endtask

    task automatic test_back_to_back();
        seen_q.delete();
        drive(1, 32'h100, 32'hFF, rand_data(), 0, 0); observe(); tick();
        drive(1, 32'h140, 32'hF0F, rand_data(), 0, 0); observe();
        n_checks++; if (cw_ack !== 1'b1) begin n_err++; $display("FAIL displace_ack2 got %0b exp 1", cw_ack); end
        tick();
        drive(1, 32'h180, 32'h3, rand_data(), 0, 0);
        for (int i = 0; i < 3; i++) begin
            observe();
            n_checks++; if (cw_ack !== exp_ack || cw_ack !== 1'b0) begin n_err++; $display("FAIL displace_stall got %0b exp 0", cw_ack); end
            tick();
        end
        dramw_ack = 1; observe();
        n_checks++; if (cw_ack !== 1'b1 || o_dramwa !== 32'h100) begin
            n_err++; $display("FAIL displace_release got ack=%0b a=%0h exp 1/100", cw_ack, o_dramwa); end
        tick();
        drive(0, '0, '0, '0, 0, 0); observe();
        n_checks++; if (dramw_rdy !== 1'b1 || o_dramwa !== 32'h140 || o_dramwd !== m_last.d) begin
            n_err++; $display("FAIL displace_second got rdy=%0b a=%0h exp 1/140", dramw_rdy, o_dramwa); end
        tick();
        drive(0, '0, '0, '0, 1, 1); observe(); tick();
        drive(0, '0, '0, '0, 0, 1); observe();
        n_checks++; if (dramw_rdy !== 1'b1 || o_dramwa !== 32'h180) begin
            n_err++; $display("FAIL displace_third got rdy=%0b a=%0h exp 1/180", dramw_rdy, o_dramwa); end
        tick();
        drive(0, '0, '0, '0, 0, 0); observe();
        n_checks++; if (seen_q.size() != 3 || seen_q[0] !== 32'h100 || seen_q[1] !== 32'h140 || seen_q[2] !== 32'h180) begin
            n_err++; $display("FAIL displace_order got %0d beats exp 100,140,180", seen_q.size()); end
        n_checks++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL displace_idle got %0b exp 1", o_idle); end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 32'h300, 32'hFFFF, rand_data(), 0, 0); observe(); tick();
        drive(1, 32'h340, 32'h1, rand_data(), 1, 0); observe();
        n_checks++; if (cw_ack !== 1'b0 || dramw_rdy !== 1'b0) begin
            n_err++; $display("FAIL flush_first got ack=%0b rdy=%0b exp 0/0", cw_ack, dramw_rdy); end
        tick(); observe();
        n_checks++; if (dramw_rdy !== 1'b1 || o_dramwa !== 32'h300 || cw_ack !== 1'b0) begin
            n_err++; $display("FAIL flush_rise got rdy=%0b a=%0h ack=%0b exp 1/300/0", dramw_rdy, o_dramwa, cw_ack); end
        tick();
        drive(0, '0, '0, '0, 0, 1); observe(); tick();
        drive(0, '0, '0, '0, 0, 0); observe();
        n_checks++; if (o_idle !== 1'b1 || dramw_rdy !== 1'b0) begin
            n_err++; $display("FAIL flush_idle got idle=%0b rdy=%0b exp 1/0", o_idle, dramw_rdy); end
        tick();
    endtask

    task automatic test_zero_race();
        int n; bit got, bad = 0;
        drive(1, 32'h500, '0, rand_data(), 0, 0); observe();
        n_checks++; if (cw_ack !== 1'b1) begin n_err++; $display("FAIL zero_ack got %0b exp 1", cw_ack); end
        tick();
        drive(0, '0, '0, '0, 0, 0);
        for (int i = 0; i < TIMEOUT + 3; i++) begin observe(); if (dramw_rdy !== 1'b0 || o_idle !== 1'b1) bad = 1; tick(); end
        n_checks++; if (bad) begin n_err++; $display("FAIL zero_discard got a beat exp none"); end
        drive(1, 32'h400, 32'h3, rand_data(), 0, 0); observe(); tick();
        drive(0, '0, '0, '0, 0, 0);
        repeat (TIMEOUT) begin observe(); tick(); end
        drive(1, 32'h400, 32'hC, rand_data(), 0, 0); observe();
        n_checks++; if (cw_ack !== 1'b1 || dramw_rdy !== 1'b0) begin
            n_err++; $display("FAIL race_ack got ack=%0b rdy=%0b exp 1/0", cw_ack, dramw_rdy); end
        tick();
        drive(0, '0, '0, '0, 0, 0); observe();
        n_checks++; if (dramw_rdy !== 1'b0) begin n_err++; $display("FAIL race_no_move got %0b exp 0", dramw_rdy); end
        tick();
        wait_rdy(30, n, got);
        n_checks++; if (!got || n != TIMEOUT || o_dramw_mask !== 32'hF || o_dramwa !== 32'h400) begin
            n_err++; $display("FAIL race_beat got n=%0d m=%0h a=%0h exp %0d/f/400", n, o_dramw_mask, o_dramwa, TIMEOUT); end
        tick();
        drive(0, '0, '0, '0, 0, 1); observe(); tick();
        drive(0, '0, '0, '0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        drive(1, 32'h600, '1, rand_data(), 0, 0); observe(); tick();
        drive(0, '0, '0, '0, 1, 0); observe(); tick();
        drive(1, 32'h640, '1, rand_data(), 0, 0); observe();
        n_checks++; if (dramw_rdy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got %0b exp 1", dramw_rdy); end
        tick();
        #2 i_rst = 0;
        #1;
        n_checks++; if (dramw_rdy !== 1'b0 || o_idle !== 1'b1 || o_dramwa !== '0) begin
            n_err++; $display("FAIL rstmid_async got rdy=%0b idle=%0b a=%0h exp 0/1/0", dramw_rdy, o_idle, o_dramwa); end
        model_reset();
        drive(0, '0, '0, '0, 0, 1);
        @(posedge i_clk); @(negedge i_clk);
        i_rst = 1;
        @(posedge i_clk); #1;
        for (int i = 0; i < TIMEOUT + 6; i++) begin observe(); if (dramw_rdy !== 1'b0 || o_idle !== 1'b1) bad = 1; tick(); end
        n_checks++; if (bad) begin n_err++; $display("FAIL rstmid_no_beat got a beat exp none"); end
        drive(0, '0, '0, '0, 0, 0);
    endtask

    task automatic test_random();
        bit mem_bad = 0;
        ref_mem.delete(); dram_mem.delete();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) < ((i % 300) < 150 ? 80 : 12)),
                  32'h100 + 32'h40 * $urandom_range(0, 2),
                  ($urandom_range(0, 5) == 0) ? '0 : CSIZE'($urandom),
                  rand_data(), ($urandom_range(0, 24) == 0), $urandom_range(0, 1) == 1);
            observe();
            n_checks++; if (cw_ack !== exp_ack) begin n_err++; $display("FAIL rnd_cw_ack cyc %0d got %0b exp %0b", i, cw_ack, exp_ack); end
            n_checks++; if (dramw_rdy !== exp_rdy) begin n_err++; $display("FAIL rnd_rdy cyc %0d got %0b exp %0b", i, dramw_rdy, exp_rdy); end
            n_checks++; if (o_idle !== exp_idle) begin n_err++; $display("FAIL rnd_idle cyc %0d got %0b exp %0b", i, o_idle, exp_idle); end
            n_checks++; if (o_dramwa !== m_last.a || o_dramw_mask !== m_last.m) begin
                n_err++; $display("FAIL rnd_beat cyc %0d got a=%0h m=%0h exp a=%0h m=%0h", i, o_dramwa, o_dramw_mask, m_last.a, m_last.m); end
            n_checks++; if (o_dramwd !== m_last.d) begin n_err++; $display("FAIL rnd_data cyc %0d lane0 got %0h exp %0h", i, o_dramwd[0], m_last.d[0]); end
            tick();
        end
        drive(0, '0, '0, '0, 1, 1);
        repeat (4) begin observe(); tick(); end
        drive(0, '0, '0, '0, 0, 0); observe();
        n_checks++; if (o_idle !== 1'b1 || m_held) begin n_err++; $display("FAIL rnd_drain got idle=%0b exp 1", o_idle); end
        foreach (ref_mem[a]) if (!dram_mem.exists(a) || dram_mem[a] !== ref_mem[a]) mem_bad = 1;
        n_checks++; if (mem_bad || dram_mem.size() != ref_mem.size()) begin
            n_err++; $display("FAIL rnd_memory got %0d lines exp %0d, content differs=%0b", dram_mem.size(), ref_mem.size(), mem_bad); end
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_merge();
        test_overwrite();
        test_back_to_back();
        test_flush();
        test_zero_race();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
